// File: rtl/i8253_pkg.sv
// Shared definitions for the 8253/8254 timer host controller.
// Holds the command opcode and FSM state encodings, the bus address of the
// control-word register, the read/load field codes and a control-word builder.
package i8253_pkg;

  // Command opcode carried on cmd_op.
  typedef enum logic {
    OP_PROGRAM = 1'b0,
    OP_READ    = 1'b1
  } op_e;

  // Bus-access phases. The access engine walks SETUP/STROBE/HOLD; DONE is the
  // completion cycle owned by the command sequencer.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_e;

  // Command sequencer states: BUSY spans the three accesses, ERR is the
  // single decode cycle of an illegal-channel command.
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_BUSY,
    SEQ_ERR,
    SEQ_DONE
  } seq_e;

  localparam logic [1:0] CW_ADDR      = 2'b11;  // control-word register
  localparam logic [1:0] RL_LATCH     = 2'b00;  // counter-latch command
  localparam logic [1:0] RL_BOTH      = 2'b11;  // load LSB then MSB
  localparam logic [1:0] CHAN_ILLEGAL = 2'd3;
  localparam logic [1:0] STEP_LAST    = 2'd2;   // MSB access of a command

  // Control word layout: {SC1:SC0, RL1:RL0, M2:M0, BCD}.
  function automatic logic [7:0] control_word(input logic [1:0] chan,
                                              input logic [1:0] rl,
                                              input logic [2:0] mode,
                                              input logic       bcd);
    return {chan, rl, mode, bcd};
  endfunction

endpackage

// File: rtl/i8253_host_access.sv
// Single timer-bus access engine: SETUP (1 cycle) -> STROBE (STROBE_CYCLES)
// -> HOLD (1 cycle). A start in IDLE or HOLD launches the next access, so
// consecutive accesses run back to back with cs held high.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, start_rd            launch an access; 1 = read, 0 = write
//   start_addr, start_data     address / write data for the launched access
//   rdata                      timer read data
//   cs, rd, wr, a, wdata       registered timer bus outputs
//   last                       engine is in HOLD (access ends this cycle)
//   rbyte                      byte captured by the most recent read
module i8253_host_access
  import i8253_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       start_rd,
  input  logic [1:0] start_addr,
  input  logic [7:0] start_data,
  input  logic [7:0] rdata,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [1:0] a,
  output logic [7:0] wdata,
  output logic       last,
  output logic [7:0] rbyte
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       op_rd_q, op_rd_d;
  logic       cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [1:0] a_q, a_d;
  logic [7:0] wdata_q, wdata_d, rbyte_q, rbyte_d;
  logic       load;

  // A new access is only taken when the bus is free or about to be.
  assign load = start && (state_q == ST_IDLE || state_q == ST_HOLD);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_rd_q <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      a_q     <= '0;
      wdata_q <= '0;
      rbyte_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      a_q     <= a_d;
      wdata_q <= wdata_d;
      rbyte_q <= rbyte_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top of a combinational block
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE:   if (load) state_d = ST_SETUP;
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = '0;
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) state_d = ST_HOLD;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      ST_HOLD:   state_d = load ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: bus outputs are registered from the next state so they
  // line up exactly with the phase the engine is in.
  always_comb begin
    op_rd_d = load ? start_rd   : op_rd_q;
    a_d     = load ? start_addr : a_q;
    wdata_d = load ? start_data : wdata_q;
    cs_d    = (state_d != ST_IDLE);
    rd_d    = (state_d == ST_STROBE) &&  op_rd_d;
    wr_d    = (state_d == ST_STROBE) && !op_rd_d;
    // Sample the timer on the edge that closes the final strobe cycle.
    rbyte_d = (state_q == ST_STROBE && cnt_q == STROBE_LAST && op_rd_q) ? rdata : rbyte_q;
  end

  assign cs    = cs_q;
  assign rd    = rd_q;
  assign wr    = wr_q;
  assign a     = a_q;
  assign wdata = wdata_q;
  assign last  = (state_q == ST_HOLD);
  assign rbyte = rbyte_q;

endmodule

// File: rtl/i8253_host.sv
// Command-level host for an 8253/8254 timer. A program command writes the
// control word and a 16-bit reload (LSB, MSB); a read command issues a
// counter-latch and reads LSB then MSB. Channel 3 is rejected with rsp_err.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_op, cmd_chan, cmd_mode,
//   cmd_bcd, cmd_count                 command fields
//   rsp_valid, rsp_data, rsp_err       one-cycle completion
//   cs, rd, wr, a, wdata, rdata        timer bus
module i8253_host
  import i8253_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [1:0]  cmd_chan,
  input  logic [2:0]  cmd_mode,
  input  logic        cmd_bcd,
  input  logic [15:0] cmd_count,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic [1:0]  a,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata
);

  seq_e        seq_q, seq_d;
  logic [1:0]  step_q, step_d;
  op_e         op_q, op_d;
  logic [1:0]  chan_q, chan_d;
  logic [2:0]  mode_q, mode_d;
  logic        bcd_q, bcd_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  lsb_q, lsb_d;
  logic        cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [15:0] rsp_data_q, rsp_data_d;

  logic        accept;
  logic        eng_start, eng_rd, eng_last;
  logic [1:0]  eng_addr;
  logic [7:0]  eng_data, eng_rbyte;

  assign accept = cmd_valid && cmd_ready_q;

  i8253_host_access #(.STROBE_CYCLES(STROBE_CYCLES)) u_access (
    .clk       (clk),
    .reset     (reset),
    .start     (eng_start),
    .start_rd  (eng_rd),
    .start_addr(eng_addr),
    .start_data(eng_data),
    .rdata     (rdata),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr),
    .a         (a),
    .wdata     (wdata),
    .last      (eng_last),
    .rbyte     (eng_rbyte)
  );

  // State register. The command registers are plain flops, reset like the
  // rest so a fresh command never sees stale fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q       <= SEQ_IDLE;
      step_q      <= '0;
      op_q        <= OP_PROGRAM;
      chan_q      <= '0;
      mode_q      <= '0;
      bcd_q       <= 1'b0;
      count_q     <= '0;
      lsb_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      seq_q       <= seq_d;
      step_q      <= step_d;
      op_q        <= op_d;
      chan_q      <= chan_d;
      mode_q      <= mode_d;
      bcd_q       <= bcd_d;
      count_q     <= count_d;
      lsb_q       <= lsb_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state and access sequencing. The first access is launched straight
  // from the live command inputs so SETUP lands in the cycle after acceptance;
  // later accesses use the registered copy.
  always_comb begin
    seq_d     = seq_q;
    step_d    = step_q;
    eng_start = 1'b0;
    eng_rd    = 1'b0;
    eng_addr  = CW_ADDR;
    eng_data  = 8'h00;
    unique case (seq_q)
      SEQ_IDLE: begin
        if (accept) begin
          step_d = '0;
          if (cmd_chan == CHAN_ILLEGAL) begin
            seq_d = SEQ_ERR;
          end else begin
            seq_d     = SEQ_BUSY;
            eng_start = 1'b1;
            eng_data  = (cmd_op == OP_READ)
                      ? control_word(cmd_chan, RL_LATCH, 3'b000, 1'b0)
                      : control_word(cmd_chan, RL_BOTH, cmd_mode, cmd_bcd);
          end
        end
      end
      SEQ_BUSY: begin
        if (eng_last) begin
          if (step_q == STEP_LAST) begin
            seq_d = SEQ_DONE;
          end else begin
            step_d    = step_q + 2'd1;
            eng_start = 1'b1;
            eng_rd    = (op_q == OP_READ);
            eng_addr  = chan_q;
            if (op_q == OP_PROGRAM)
              eng_data = (step_q == 2'd0) ? count_q[7:0] : count_q[15:8];
          end
        end
      end
      SEQ_ERR:  seq_d = SEQ_DONE;
      default:  seq_d = SEQ_IDLE;
    endcase
  end

  // Registered outputs and command capture.
  always_comb begin
    cmd_ready_d = (seq_d == SEQ_IDLE);
    rsp_valid_d = (seq_d == SEQ_DONE);
    rsp_err_d   = (seq_d == SEQ_DONE) && (seq_q == SEQ_ERR);
    rsp_data_d  = (seq_d == SEQ_DONE && seq_q == SEQ_BUSY && op_q == OP_READ)
                ? {eng_rbyte, lsb_q} : 16'h0000;
    // The LSB read finishes at step 1; keep it until the MSB arrives.
    lsb_d   = (seq_q == SEQ_BUSY && eng_last && step_q == 2'd1) ? eng_rbyte : lsb_q;
    op_d    = accept ? op_e'(cmd_op) : op_q;
    chan_d  = accept ? cmd_chan      : chan_q;
    mode_d  = accept ? cmd_mode      : mode_q;
    bcd_d   = accept ? cmd_bcd       : bcd_q;
    count_d = accept ? cmd_count     : count_q;
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule
